// File: rtl/RV32I_definitions.sv
// -----------------------------------------------------------------------------
// RV32I_definitions
// Shared definitions for the RV32I pipeline.
//   NOP            : canonical RV32I no-op (addi x0, x0, 0)
//   if_id_entry_t  : one IF->ID buffer entry {pc, instr, misaligned}
// -----------------------------------------------------------------------------
package RV32I_definitions;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_skid_fifo.sv
// -----------------------------------------------------------------------------
// if_id_skid_fifo
// Two-entry storage for the IF->ID boundary. It holds the entries, the
// read/write pointers and the occupancy count, and applies flushes.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_valid   : upstream offers wr_entry
//   wr_entry   : entry to store
//   wr_ready   : room for an entry (decoded from registered count only)
//   rd_stall   : downstream cannot take the head this cycle
//   flush      : drop everything, including same-cycle push/pop
//   rd_valid   : head entry is valid
//   rd_entry   : head entry
// -----------------------------------------------------------------------------
module if_id_skid_fifo
  import RV32I_definitions::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_valid,
  input  if_id_entry_t wr_entry,
  output logic         wr_ready,
  input  logic         rd_stall,
  input  logic         flush,
  output logic         rd_valid,
  output if_id_entry_t rd_entry
);

  if_id_entry_t entry_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;

  logic push;
  logic pop;

  // Ready depends only on registered count, so a decode stall never
  // reaches the fetch stage combinationally.
  assign wr_ready = (count_q != 2'(DEPTH));
  assign rd_valid = (count_q != 2'd0);
  assign rd_entry = entry_q[rd_ptr_q];

  assign push = wr_valid & wr_ready & ~flush;
  assign pop  = rd_valid & ~rd_stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too (only two entries) so the head reads
      // PC=0 out of reset rather than an X from an unwritten entry.
      for (int i = 0; i < 2; i++) entry_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      // Entry contents are left stale; they are unreachable once count is 0.
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read above sees
      // the pre-edge value regardless of statement order.
      if (push) begin
        entry_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_id_pipe.sv
// -----------------------------------------------------------------------------
// if_id_pipe
// Registered IF->ID boundary of the RV32I pipeline: a two-entry skid buffer
// between fetch and decode, with flush, misaligned-PC flagging and saturating
// stall/flush performance counters.
//   Clk, Reset_n                      : clock, asynchronous active-low reset
//   IF_Valid, IF_PC, IF_Instruction   : fetch-side entry offer
//   IF_Ready                          : block can accept an entry
//   ID_Stall, ID_Flush                : decode-side stall and flush
//   ID_Valid, ID_PC, ID_Instruction   : head entry (NOP when not valid)
//   ID_Misaligned                     : head entry PC[1:0] != 0
//   Stall_count, Flush_count          : saturating event counters
// Only DEPTH = 2 is supported.
// -----------------------------------------------------------------------------
module if_id_pipe
  import RV32I_definitions::*;
#(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 IF_Valid,
  input  logic [31:0]          IF_PC,
  input  logic [31:0]          IF_Instruction,
  output logic                 IF_Ready,
  input  logic                 ID_Stall,
  input  logic                 ID_Flush,
  output logic                 ID_Valid,
  output logic [31:0]          ID_PC,
  output logic [31:0]          ID_Instruction,
  output logic                 ID_Misaligned,
  output logic [CNT_WIDTH-1:0] Stall_count,
  output logic [CNT_WIDTH-1:0] Flush_count
);

  if_id_entry_t wr_entry;
  if_id_entry_t head;

  // Misalignment is judged once, at capture, and travels with the entry.
  assign wr_entry = '{pc: IF_PC, instr: IF_Instruction, misaligned: |IF_PC[1:0]};

  if_id_skid_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .wr_valid (IF_Valid),
    .wr_entry (wr_entry),
    .wr_ready (IF_Ready),
    .rd_stall (ID_Stall),
    .flush    (ID_Flush),
    .rd_valid (ID_Valid),
    .rd_entry (head)
  );

  assign ID_PC          = head.pc;
  assign ID_Misaligned  = head.misaligned;
  assign ID_Instruction = ID_Valid ? head.instr : NOP;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Stall_count <= '0;
      Flush_count <= '0;
    end else begin
      if (ID_Valid && ID_Stall && (Stall_count != '1))
        Stall_count <= Stall_count + 1'b1;
      if (ID_Flush && (Flush_count != '1))
        Flush_count <= Flush_count + 1'b1;
    end
  end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Registered IF→ID boundary of the RV32I pipeline. Accepts fetched PC/instruction pairs from the fetch stage through a valid/ready handshake, buffers up to two entries, and presents the oldest one to the decode stage. The block removes the combinational path from a decode stall back to the fetch stage. It applies flushes from branch and jump resolution, flags misaligned PCs, and keeps saturating stall and flush counters.

## Interface
Parameters:
- DEPTH, 2, buffer entries (fixed at 2; any other value is unsupported)
- CNT_WIDTH, 16, width of the performance counters

Ports:
- Clk  in  1  pipeline clock. One clock only; every state change happens on the rising edge of Clk.
- Reset_n  in  1  asynchronous, active-low reset
- IF_Valid  in  1  fetch stage presents a valid entry
- IF_PC  in  32  PC of the fetched instruction
- IF_Instruction  in  32  fetched instruction word
- IF_Ready  out  1  block can accept an entry this cycle
- ID_Stall  in  1  decode cannot consume the head entry this cycle
- ID_Flush  in  1  discard all buffered entries and any same-cycle input
- ID_Valid  out  1  head entry is valid
- ID_PC  out  32  PC of the head entry
- ID_Instruction  out  32  instruction of the head entry; NOP when ID_Valid=0
- ID_Misaligned  out  1  head entry's PC[1:0] != 2'b00
- Stall_count  out  CNT_WIDTH  number of cycles with ID_Valid=1 and ID_Stall=1
- Flush_count  out  CNT_WIDTH  number of cycles with ID_Flush=1

## Operation
- State: two entries {pc, instr, misaligned}, rd_ptr (1 bit), wr_ptr (1 bit), count (0..2).
- Push = IF_Valid & IF_Ready & ~ID_Flush. The entry is written at wr_ptr, and wr_ptr toggles.
- Pop = ID_Valid & ~ID_Stall & ~ID_Flush. rd_ptr toggles.
- Next count:
  - push & pop: count is unchanged.
  - push only: count+1.
  - pop only: count-1.
- IF_Ready = (count != 2). It is decoded from registered count only and never depends on ID_Stall in the same cycle.
- ID_Valid = (count != 0).
- ID_PC and ID_Misaligned come from entry[rd_ptr].
- ID_Instruction = entry[rd_ptr].instr when ID_Valid=1, otherwise NOP 32'h00000013.
- misaligned is computed as |IF_PC[1:0] at push time and stored with the entry.
- Flush: count, rd_ptr and wr_ptr go to 0. Any push or pop in the same cycle is suppressed. Flush has priority over every other event.
- Counters saturate at all-ones and never wrap.
  - Stall_count increments when ID_Valid & ID_Stall.
  - Flush_count increments when ID_Flush.
- A push while count=2 cannot occur, because IF_Ready=0. If IF_Valid is held, the entry must be held upstream.
- A pop while count=0 cannot occur, because ID_Valid=0. ID_Stall is a don't-care in that cycle.

## Timing
- Reset (asynchronous assert, synchronous-to-Clk deassert assumed upstream) drives:
  - count=0, rd_ptr=0, wr_ptr=0
  - ID_Valid=0, ID_PC=0, ID_Instruction=32'h00000013, ID_Misaligned=0
  - IF_Ready=1
  - Stall_count=0, Flush_count=0
- Reset asserted mid-operation discards all buffered entries immediately. Counters clear.
- Latency: an entry pushed at edge N is visible on ID_* after edge N when the buffer was empty. Otherwise it becomes visible once the older entry pops.
- Throughput: one entry per cycle with no stalls. Occupancy stays at 1 in steady state.
- IF_Ready falls one cycle after the second unpopped push. It rises the cycle after the first pop from full.
- A flush at edge N gives ID_Valid=0 and IF_Ready=1 after edge N. A push at edge N+1 is accepted normally.
- Outputs are registered or decoded from registered state only. There are no combinational input-to-output paths.

## Structure
- The shared package RV32I_definitions gains:
  - the NOP constant (32'h00000013)
  - a packed struct typedef if_id_entry_t {pc[31:0], instr[31:0], misaligned}
- Sub-module if_id_skid_fifo holds the 2-entry storage, pointers, count and flush logic.
- The top level adds the NOP substitution, the misaligned computation and the saturating counters.

## Test plan
- Reset, then stream PCs 0x0,0x4,0x8 with IF_Valid=1 and ID_Stall=0 → ID_PC follows one cycle behind; IF_Ready stays 1; count never exceeds 1.
- Push 0x10 and 0x14 with ID_Stall=1 → IF_Ready=0 after the second push; ID_PC holds 0x10; Stall_count increments every stalled cycle. Release the stall → 0x10 then 0x14 pop in order.
- Buffer holds 2 entries, then ID_Flush=1 together with IF_Valid=1 (PC 0x20) → next cycle ID_Valid=0, ID_Instruction=32'h00000013, 0x20 is not captured; Flush_count=1.
- Push PC 0x22 → ID_Misaligned=1 on that entry; push 0x24 → ID_Misaligned=0.
- Assert Reset_n=0 asynchronously while 2 entries are buffered → ID_Valid=0 and IF_Ready=1 before the next edge; counters read 0.
- Hold ID_Stall=1 with a valid head for 2^CNT_WIDTH+5 cycles → Stall_count saturates at all-ones.
